hazard_stall_ctrl: RTL and testbench



---
 rtl/hazard_stall_ctrl_if.sv | 34 +++
 rtl/hazard_stall_ctrl.sv | 148 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard/stall control bundle: hazard and memory-handshake inputs plus pipeline enables/flushes.
// Latency: pure wiring, no storage.
// Backpressure: dmem_req/dmem_ready form the only handshake; the controller freezes the pipeline while it is unfinished.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             load_use_en;
    logic             branch_taken;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_we;
    logic             idex_flush;
    logic             exmem_we;
    logic             mem_err;
    logic [CNT_W-1:0] lu_stall_cnt;
    logic [CNT_W-1:0] mem_stall_cnt;

    // Pipeline side: supplies hazard/memory status, consumes the control.
    modport master (
        output load_use_en, branch_taken, dmem_req, dmem_ready,
        input  pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we,
        input  mem_err, lu_stall_cnt, mem_stall_cnt
    );

    // Controller side.
    modport slave (
        input  load_use_en, branch_taken, dmem_req, dmem_ready,
        output pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we,
        output mem_err, lu_stall_cnt, mem_stall_cnt
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller for the 5-stage core: memory wait states, branch flushes, load-use bubbles.
// Latency: control outputs are combinational (same cycle); state, wait counter, error flag and perf counters are registered.
// Backpressure: an unfinished data-memory access freezes every stage for at most MEM_TIMEOUT-1 cycles; STALL_PERF_CNT_EN adds stall counters.
module hazard_stall_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    hazard_stall_ctrl_if.slave bus
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // Last wait count tolerated before the access is forced to complete.
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] wcnt_q;
    logic       mem_err_q;

    logic mem_pending;
    logic timeout_hit;
    logic mem_stall;

    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_we;
    logic idex_flush;
    logic exmem_we;

    // Access outstanding this cycle; the timeout cycle is released as if the memory had answered.
    always_comb begin
        mem_pending = bus.dmem_req & ~bus.dmem_ready;
        timeout_hit = (state_q == MEM_WAIT) && mem_pending && (wcnt_q >= TMO_LAST);
        mem_stall   = mem_pending & ~timeout_hit;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: wait while the access is stalled, otherwise run.
    always_comb begin
        state_d = state_q;
        if (mem_stall) begin
            state_d = MEM_WAIT;
        end else begin
            state_d = RUN;
        end
    end

    // Control outputs by priority: reset, memory freeze, branch flush, load-use bubble.
    always_comb begin
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        ifid_flush = 1'b0;
        idex_we    = 1'b1;
        idex_flush = 1'b0;
        exmem_we   = 1'b1;
        if (rst) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            ifid_flush = 1'b1;
            idex_we    = 1'b0;
            idex_flush = 1'b1;
            exmem_we   = 1'b0;
        end else if (mem_stall) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
        end else if (bus.branch_taken) begin
            // Wrong-path instruction in ID: a pending load-use hazard is moot.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (bus.load_use_en) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // Wait counter restarts on every release; the error flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q    <= 8'd0;
            mem_err_q <= 1'b0;
        end else begin
            if (mem_stall) begin
                wcnt_q <= wcnt_q + 8'd1;
            end else begin
                wcnt_q <= 8'd0;
            end
            if (timeout_hit) begin
                mem_err_q <= 1'b1;
            end
        end
    end

    assign bus.pc_we      = pc_we;
    assign bus.ifid_we    = ifid_we;
    assign bus.ifid_flush = ifid_flush;
    assign bus.idex_we    = idex_we;
    assign bus.idex_flush = idex_flush;
    assign bus.exmem_we   = exmem_we;
    assign bus.mem_err    = mem_err_q;

`ifdef STALL_PERF_CNT_EN
    logic             lu_bubble;
    logic [CNT_W-1:0] lu_cnt_q;
    logic [CNT_W-1:0] ms_cnt_q;

    assign lu_bubble = ~rst & ~mem_stall & ~bus.branch_taken & bus.load_use_en;

    // Saturating counts of inserted bubbles and frozen memory cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            lu_cnt_q <= '0;
            ms_cnt_q <= '0;
        end else begin
            if (lu_bubble && (lu_cnt_q != '1)) begin
                lu_cnt_q <= lu_cnt_q + 1'b1;
            end
            if (mem_stall && (ms_cnt_q != '1)) begin
                ms_cnt_q <= ms_cnt_q + 1'b1;
            end
        end
    end

    assign bus.lu_stall_cnt  = lu_cnt_q;
    assign bus.mem_stall_cnt = ms_cnt_q;
`else
    assign bus.lu_stall_cnt  = '0;
    assign bus.mem_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed test-plan sequences then randomized traffic against a cycle-level reference model.
// Latency: expected values are queued per cycle and compared half a cycle later by an independent monitor.
// Backpressure: long dmem_ready droughts are generated on purpose to reach the timeout path.
module tb_hazard_stall_ctrl;
    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_W       = 16;
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hazard_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_stall_ctrl #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ctl order: pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, mem_err
    typedef struct packed {
        logic [6:0]       ctl;
        logic [CNT_W-1:0] lu;
        logic [CNT_W-1:0] ms;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   perf_en;

    // Reference model state: frozen cycles spent on the current access, sticky error, counts.
    int     waited;
    bit     err;
    longint lu_cnt;
    longint ms_cnt;

    task automatic check(input string name, input obs_t got, input obs_t want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got ctl=%b lu=%0d ms=%0d, want ctl=%b lu=%0d ms=%0d",
                     name, got.ctl, got.lu, got.ms, want.ctl, want.lu, want.ms);
        end
    endtask

    // One clock cycle: drive inputs, predict outputs, advance the model as the clock edge will.
    task automatic cyc(input bit r, input bit lu, input bit br, input bit req, input bit rdy);
        obs_t e;
        bit pend, tmo, frozen;
        rst              = r;
        bus.load_use_en  = lu;
        bus.branch_taken = br;
        bus.dmem_req     = req;
        bus.dmem_ready   = rdy;

        pend   = req && !rdy;
        tmo    = pend && (waited > 0) && (waited >= MEM_TIMEOUT - 1);
        frozen = !r && pend && !tmo;

        if (r)           e.ctl[6:1] = 6'b001010;
        else if (frozen) e.ctl[6:1] = 6'b000000;
        else if (br)     e.ctl[6:1] = 6'b111111;
        else if (lu)     e.ctl[6:1] = 6'b000111;
        else             e.ctl[6:1] = 6'b110101;
        e.ctl[0] = err;
        e.lu     = perf_en ? CNT_W'(lu_cnt) : '0;
        e.ms     = perf_en ? CNT_W'(ms_cnt) : '0;
        exp_q.push_back(e);

        if (r) begin
            waited = 0;
            err    = 1'b0;
            lu_cnt = 0;
            ms_cnt = 0;
        end else begin
            waited = frozen ? waited + 1 : 0;
            if (tmo) err = 1'b1;
            if (frozen && ms_cnt < CNT_MAX) ms_cnt++;
            if (!frozen && !br && lu && lu_cnt < CNT_MAX) lu_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle the DUT presents control, compare it with the oldest prediction.
    initial begin
        int   idx;
        obs_t got, want;
        idx = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got.ctl = {bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_we,
                           bus.idex_flush, bus.exmem_we, bus.mem_err};
                got.lu  = bus.lu_stall_cnt;
                got.ms  = bus.mem_stall_cnt;
                check($sformatf("cycle%0d", idx), got, want);
                idx++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time exhausted, got no finish, want finish");
        $fatal(1);
    end

    initial begin
        bit slow;
        obs_t dummy;
`ifdef STALL_PERF_CNT_EN
        perf_en = 1'b1;
`else
        perf_en = 1'b0;
`endif
        waited = 0;
        err    = 1'b0;
        lu_cnt = 0;
        ms_cnt = 0;
        rst              = 1'b1;
        bus.load_use_en  = 1'($urandom);
        bus.branch_taken = 1'($urandom);
        bus.dmem_req     = 1'($urandom);
        bus.dmem_ready   = 1'($urandom);
        @(posedge clk);
        #1;

        // Reset held with random inputs.
        for (int i = 0; i < 2; i++)
            cyc(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        cyc(0, 0, 0, 0, 0);

        // Single load-use bubble.
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // Three wait states then completion.
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0);

        // Memory never answers: 14 frozen cycles, forced release on the 15th, sticky error.
        for (int i = 0; i < MEM_TIMEOUT; i++) cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);

        // Branch overrides load-use.
        cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // Branch held through a memory stall flushes only on release.
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 1, 1);
        cyc(0, 0, 0, 0, 0);

        // Reset clears the sticky error; back-to-back load-use gives one bubble per cycle.
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);

        // Randomized traffic with occasional slow-memory phases to reach the timeout.
        slow = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            bit r, lu, br, req, rdy;
            if ($urandom_range(0, 49) == 0) slow = ~slow;
            r   = ($urandom_range(0, 199) == 0);
            lu  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 5) == 0);
            req = slow ? ($urandom_range(0, 7) != 0) : 1'($urandom);
            rdy = slow ? ($urandom_range(0, 19) == 0) : 1'($urandom);
            cyc(r, lu, br, req, rdy);
        end

        // All predictions must have been consumed by the monitor.
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d pending predictions, want 0", exp_q.size());
            dummy = '0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
